// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcodes, ALU select codes, FSM states and decode helpers for cpu_ctrl
package cpu_ctrl_pkg;

    localparam logic [2:0] OP_MOV  = 3'b000;
    localparam logic [2:0] OP_JZ   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_JMP  = 3'b101;
    localparam logic [2:0] OP_OUT  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ZTST = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_SHL  = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic       imm_sel;
        logic [7:0] imm;
    } instr_t;

    // Opcodes 000..100 go through the EXEC/WB path of the ALU.
    function automatic logic op_uses_alu(input logic [2:0] op);
        return (op <= OP_SHL);
    endfunction

    // JZ uses the ALU only for its zero flag; everything else on the ALU path writes rd.
    function automatic logic op_writes_rd(input logic [2:0] op);
        return (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHL);
    endfunction

    function automatic logic [2:0] alu_sel_of(input logic [2:0] op);
        logic [2:0] sel;
        case (op)
            OP_JZ:   sel = ALU_ZTST;
            OP_ADD:  sel = ALU_ADD;
            OP_SUB:  sel = ALU_SUB;
            OP_SHL:  sel = ALU_SHL;
            default: sel = ALU_PASS;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - registered 8-bit ALU driven by cpu_ctrl
module cpu_alu
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       alu_en,
    input  logic [2:0] alu_sel,
    input  logic [7:0] alu_in1,
    input  logic [7:0] alu_in2,
    output logic [7:0] alu_out,
    output logic       alu_zero
);

    logic [7:0] result;

    // Combinational operation select; shifts of 8 or more naturally give 0.
    always_comb begin
        result = alu_in1;
        case (alu_sel)
            ALU_PASS: result = alu_in1;
            ALU_ZTST: result = alu_in1;
            ALU_ADD:  result = alu_in1 + alu_in2;
            ALU_SUB:  result = alu_in1 - alu_in2;
            ALU_SHL:  result = alu_in1 << alu_in2;
            default:  result = alu_in1;
        endcase
    end

    // Result and zero flag are registered, valid the cycle after alu_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out  <= '0;
            alu_zero <= 1'b0;
        end else if (alu_en) begin
            alu_out  <= result;
            alu_zero <= (result == 8'd0);
        end
    end

endmodule

// File: rtl/cpu_ctrl_regfile.sv
// rtl/cpu_ctrl_regfile.sv - 4x8 register file, two async read ports, one sync write port
module cpu_regfile #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [1:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [4];

    // Reads are combinational so DECODE sees the pre-write value even when rd==rs.
    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

    // Single write port, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - fetch/decode/execute control unit driving the registered ALU
module cpu_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [PC_W-1:0]   pc,
    output logic              instr_req,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              alu_en,
    output logic [2:0]        alu_sel,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted
);

    state_t            state, state_n;
    instr_t            ir, ir_n;
    logic [PC_W-1:0]   pc_n;
    logic              instr_req_n;
    logic              alu_en_n;
    logic [2:0]        alu_sel_n;
    logic [DATA_W-1:0] alu_in1_n;
    logic [DATA_W-1:0] alu_in2_n;
    logic [DATA_W-1:0] out_data_n;
    logic              out_valid_n;
    logic              halted_n;

    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic [DATA_W-1:0] src;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   pc_imm;
    logic              rf_we;

    assign src    = ir.imm_sel ? DATA_W'(ir.imm) : rdata_b;
    assign pc_inc = pc + PC_W'(1);
    assign pc_imm = PC_W'(ir.imm);
    // alu_out is only consumed here, in WB, one cycle after the EXEC pulse.
    assign rf_we  = (state == ST_WB) && op_writes_rd(ir.op);

    cpu_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (ir.rd),
        .wdata   (alu_out),
        .raddr_a (ir.rd),
        .rdata_a (rdata_a),
        .raddr_b (ir.rs),
        .rdata_b (rdata_b)
    );

    // State and every output are registered; reset drops straight back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ir        <= '0;
            pc        <= RESET_PC;
            instr_req <= 1'b0;
            alu_en    <= 1'b0;
            alu_sel   <= '0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_n;
            ir        <= ir_n;
            pc        <= pc_n;
            instr_req <= instr_req_n;
            alu_en    <= alu_en_n;
            alu_sel   <= alu_sel_n;
            alu_in1   <= alu_in1_n;
            alu_in2   <= alu_in2_n;
            out_data  <= out_data_n;
            out_valid <= out_valid_n;
            halted    <= halted_n;
        end
    end

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        state_n     = state;
        ir_n        = ir;
        pc_n        = pc;
        instr_req_n = instr_req;
        alu_en_n    = 1'b0;
        alu_sel_n   = alu_sel;
        alu_in1_n   = alu_in1;
        alu_in2_n   = alu_in2;
        out_data_n  = out_data;
        out_valid_n = 1'b0;
        halted_n    = halted;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n     = ST_FETCH;
                    pc_n        = RESET_PC;
                    instr_req_n = 1'b1;
                end
            end

            ST_FETCH: begin
                if (instr_req && instr_valid) begin
                    ir_n        = instr_t'(instr);
                    instr_req_n = 1'b0;
                    state_n     = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (op_uses_alu(ir.op)) begin
                    alu_sel_n = alu_sel_of(ir.op);
                    // MOV passes its source through operand 1.
                    alu_in1_n = (ir.op == OP_MOV) ? src : rdata_a;
                    alu_in2_n = src;
                    alu_en_n  = 1'b1;
                    state_n   = ST_EXEC;
                end else begin
                    case (ir.op)
                        OP_JMP: begin
                            pc_n        = pc_imm;
                            instr_req_n = 1'b1;
                            state_n     = ST_FETCH;
                        end
                        OP_OUT: begin
                            out_data_n  = src;
                            out_valid_n = 1'b1;
                            pc_n        = pc_inc;
                            instr_req_n = 1'b1;
                            state_n     = ST_FETCH;
                        end
                        default: begin
                            halted_n = 1'b1;
                            state_n  = ST_HALT;
                        end
                    endcase
                end
            end

            ST_EXEC: begin
                state_n = ST_WB;
            end

            ST_WB: begin
                pc_n        = (ir.op == OP_JZ && alu_zero) ? pc_imm : pc_inc;
                instr_req_n = 1'b1;
                state_n     = ST_FETCH;
            end

            ST_HALT: begin
                if (start) begin
                    halted_n    = 1'b0;
                    pc_n        = RESET_PC;
                    instr_req_n = 1'b1;
                    state_n     = ST_FETCH;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - self-checking bench for cpu_ctrl with ALU and variable-latency ROM
module tb_cpu_ctrl;
    import cpu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] pc;
    logic       instr_req;
    logic       instr_valid;
    logic [15:0] instr;
    logic       alu_en;
    logic [2:0] alu_sel;
    logic [7:0] alu_in1, alu_in2, alu_out;
    logic       alu_zero;
    logic [7:0] out_data;
    logic       out_valid;
    logic       halted;

    always #5 clk = ~clk;

    cpu_ctrl #(.PC_W(8), .RESET_PC(8'h00), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .instr_req(instr_req),
        .instr_valid(instr_valid), .instr(instr), .alu_en(alu_en), .alu_sel(alu_sel),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out), .alu_zero(alu_zero),
        .out_data(out_data), .out_valid(out_valid), .halted(halted)
    );

    cpu_alu u_alu (
        .clk(clk), .rst(rst), .alu_en(alu_en), .alu_sel(alu_sel), .alu_in1(alu_in1),
        .alu_in2(alu_in2), .alu_out(alu_out), .alu_zero(alu_zero)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    logic [15:0] rom [256];
    int          fetch_cnt [256];
    logic [7:0]  out_log [$];

    function automatic logic [15:0] ins_i(input logic [2:0] op, input logic [1:0] rd, input logic [7:0] imm);
        return {op, rd, 2'b00, 1'b1, imm};
    endfunction

    function automatic logic [15:0] ins_r(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs);
        return {op, rd, rs, 1'b0, 8'h00};
    endfunction

    // ---------------- ISA-level model ----------------
    logic [7:0] m_r [4];
    logic [7:0] m_pc;
    bit         m_running, m_halted;
    int         cyc = 0, halt_cyc = 0, hs_cyc = 0, exp_lat = 0;
    logic [7:0] exp_out [$];
    bit         alu_pend, e_chk2;
    logic [2:0] e_sel;
    logic [7:0] e_in1, e_in2;
    bit         prev_req, prev_out_valid, prev_alu_en;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 8'd0;
        m_pc = 8'd0; m_running = 0; m_halted = 0;
        exp_out.delete(); alu_pend = 0; exp_lat = 0;
        prev_req = 0; prev_out_valid = 0; prev_alu_en = 0;
    endtask

    task automatic model_exec(input logic [15:0] ins);
        logic [2:0] op;
        logic [1:0] rd, rs;
        logic [7:0] imm, src, nxt;
        op = ins[15:13]; rd = ins[12:11]; rs = ins[10:9]; imm = ins[7:0];
        src = ins[8] ? imm : m_r[rs];
        nxt = m_pc + 8'd1;
        exp_lat = 4; alu_pend = 1; e_in1 = m_r[rd]; e_in2 = src; e_chk2 = 0; e_sel = ALU_PASS;
        case (op)
            OP_MOV: begin e_sel = ALU_PASS; e_in1 = src; m_r[rd] = src; end
            OP_JZ:  begin e_sel = ALU_ZTST; if (m_r[rd] == 8'd0) nxt = imm; end
            OP_ADD: begin e_sel = ALU_ADD; e_chk2 = 1; m_r[rd] = m_r[rd] + src; end
            OP_SUB: begin e_sel = ALU_SUB; e_chk2 = 1; m_r[rd] = m_r[rd] - src; end
            OP_SHL: begin e_sel = ALU_SHL; e_chk2 = 1; m_r[rd] = (src >= 8'd8) ? 8'd0 : 8'(m_r[rd] << src); end
            OP_JMP: begin exp_lat = 2; alu_pend = 0; nxt = imm; end
            OP_OUT: begin exp_lat = 2; alu_pend = 0; exp_out.push_back(src); end
            default: begin exp_lat = 0; alu_pend = 0; m_halted = 1; m_running = 0; halt_cyc = cyc; end
        endcase
        m_pc = nxt;
    endtask

    // Compare process: every negedge, checks DUT outputs against the model.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                model_reset();
                check("reset_outputs", {pc, instr_req, alu_en, alu_sel, alu_in1, alu_in2, out_data, out_valid, halted}, 64'd0);
            end else begin
                if (out_valid) begin
                    check("out_valid_pulse", prev_out_valid, 0);
                    if (exp_out.size() == 0) check("out_unexpected", 1, 0);
                    else check("out_data", out_data, exp_out.pop_front());
                    out_log.push_back(out_data);
                end
                if (alu_en) begin
                    check("alu_en_pulse", prev_alu_en, 0);
                    check("alu_en_expected", alu_pend, 1);
                    check("alu_sel", alu_sel, e_sel);
                    check("alu_in1", alu_in1, e_in1);
                    if (e_chk2) check("alu_in2", alu_in2, e_in2);
                    alu_pend = 0;
                end
                if (instr_req && !prev_req && exp_lat != 0) begin
                    check("latency", cyc - hs_cyc, exp_lat);
                    exp_lat = 0;
                end
                if (m_halted && cyc >= halt_cyc + 2) begin
                    check("halted_high", halted, 1);
                    check("no_req_in_halt", instr_req, 0);
                end else if (m_running && !m_halted) begin
                    check("halted_low", halted, 0);
                end
                if (!m_running && !m_halted) check("no_req_in_idle", instr_req, 0);
                if (instr_req && instr_valid) begin
                    check("fetch_while_running", m_running, 1);
                    check("fetch_pc", pc, m_pc);
                    fetch_cnt[pc]++;
                    hs_cyc = cyc;
                    model_exec(rom[m_pc]);
                end
                if (start && !m_running) begin
                    m_pc = 8'h00; m_running = 1; m_halted = 0;
                end
                prev_req = instr_req; prev_out_valid = out_valid; prev_alu_en = alu_en;
            end
        end
    end

    // ROM model: 1-3 cycle latency, plus stray instr_valid pulses carrying HALT while idle.
    initial begin
        int wcnt;
        wcnt = 0; instr_valid = 0; instr = 16'h0000;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                instr_valid = 0;
            end else if (instr_req) begin
                if (wcnt == 0) begin instr_valid = 1; instr = rom[pc]; end
                else begin instr_valid = 0; instr = 16'hE000; wcnt--; end
            end else begin
                instr_valid = ($urandom_range(0, 2) == 0);
                instr = 16'hE000;
                wcnt = $urandom_range(0, 2);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1; rst = 1;
        repeat (2) @(posedge clk);
        #1; rst = 0;
    endtask

    task automatic load_clear();
        for (int i = 0; i < 256; i++) begin rom[i] = 16'hE000; fetch_cnt[i] = 0; end
        out_log.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1; start = 1;
        @(posedge clk); #1; start = 0;
    endtask

    task automatic wait_halt(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (halted && m_halted) break;
        end
        check(name, halted, 1);
        check({name, "_drained"}, exp_out.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        bit found;
        load_clear();
        repeat (2) @(posedge clk);
        #1; rst = 0;

        // 1: MOV/ADD/OUT, rd==rs add, start while busy ignored
        load_clear();
        rom[0] = ins_i(OP_MOV, 2'd0, 8'd5);
        rom[1] = ins_i(OP_ADD, 2'd0, 8'd3);
        rom[2] = ins_r(OP_OUT, 2'd0, 2'd0);
        rom[3] = ins_r(OP_ADD, 2'd0, 2'd0);
        rom[4] = ins_r(OP_OUT, 2'd0, 2'd0);
        rom[5] = ins_r(OP_HALT, 2'd0, 2'd0);
        pulse_start();
        repeat (6) @(posedge clk);
        pulse_start();
        wait_halt("t1_halt");
        check("t1_out_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            check("t1_out0", out_log[0], 8'd8);
            check("t1_out1", out_log[1], 8'd16);
        end
        check("t1_pc0_fetched_once", fetch_cnt[0], 1);

        // 2: SUB wrap
        do_reset(); load_clear();
        rom[0] = ins_i(OP_MOV, 2'd1, 8'd2);
        rom[1] = ins_i(OP_SUB, 2'd1, 8'd3);
        rom[2] = ins_r(OP_OUT, 2'd0, 2'd1);
        rom[3] = ins_r(OP_HALT, 2'd0, 2'd0);
        pulse_start();
        wait_halt("t2_halt");
        check("t2_out_count", out_log.size(), 1);
        if (out_log.size() == 1) check("t2_out0", out_log[0], 8'hFF);

        // 3: JZ taken (R2=0) and not taken (R2=1)
        for (int v = 0; v < 2; v++) begin
            do_reset(); load_clear();
            rom[0]  = ins_i(OP_MOV, 2'd2, 8'(v));
            rom[1]  = ins_i(OP_MOV, 2'd0, 8'd0);
            rom[2]  = ins_i(OP_JZ, 2'd2, 8'd10);
            rom[3]  = ins_i(OP_OUT, 2'd0, 8'd3);
            rom[4]  = ins_r(OP_HALT, 2'd0, 2'd0);
            rom[10] = ins_i(OP_OUT, 2'd0, 8'd7);
            rom[11] = ins_r(OP_HALT, 2'd0, 2'd0);
            pulse_start();
            wait_halt("t3_halt");
            check("t3_out_count", out_log.size(), 1);
            if (out_log.size() == 1) check("t3_out0", out_log[0], (v == 0) ? 8'd7 : 8'd3);
            check("t3_fetch10", fetch_cnt[10], (v == 0) ? 1 : 0);
            check("t3_fetch3", fetch_cnt[3], (v == 0) ? 0 : 1);
        end

        // 4: SHL to 0x80, to 0, shift >= 8, JMP to 255 and pc wrap
        do_reset(); load_clear();
        rom[0]   = ins_i(OP_JZ, 2'd2, 8'd20);
        rom[1]   = ins_r(OP_HALT, 2'd0, 2'd0);
        rom[20]  = ins_i(OP_MOV, 2'd3, 8'd1);
        rom[21]  = ins_i(OP_SHL, 2'd3, 8'd7);
        rom[22]  = ins_r(OP_OUT, 2'd0, 2'd3);
        rom[23]  = ins_i(OP_SHL, 2'd3, 8'd1);
        rom[24]  = ins_r(OP_OUT, 2'd0, 2'd3);
        rom[25]  = ins_i(OP_MOV, 2'd1, 8'd3);
        rom[26]  = ins_i(OP_SHL, 2'd1, 8'd9);
        rom[27]  = ins_r(OP_OUT, 2'd0, 2'd1);
        rom[28]  = ins_i(OP_JMP, 2'd0, 8'd255);
        rom[255] = ins_i(OP_MOV, 2'd2, 8'd1);
        pulse_start();
        wait_halt("t4_halt");
        check("t4_out_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            check("t4_shl7", out_log[0], 8'h80);
            check("t4_shl_out", out_log[1], 8'h00);
            check("t4_shl9", out_log[2], 8'h00);
        end
        check("t4_fetch255", fetch_cnt[255], 1);
        check("t4_pc_wrap", fetch_cnt[0], 2);

        // 7: JZ to its own address spins until reset
        do_reset(); load_clear();
        rom[0] = ins_i(OP_JZ, 2'd0, 8'd0);
        pulse_start();
        repeat (60) @(negedge clk);
        check("spin_loop", fetch_cnt[0] >= 3, 1);
        check("spin_not_halted", halted, 0);

        // 5: HALT, idle while halted, restart with registers retained
        do_reset(); load_clear();
        rom[0] = ins_r(OP_OUT, 2'd0, 2'd1);
        rom[1] = ins_i(OP_MOV, 2'd1, 8'd4);
        rom[2] = ins_r(OP_HALT, 2'd0, 2'd0);
        pulse_start();
        wait_halt("t5_halt1");
        repeat (20) @(negedge clk);
        check("t5_no_refetch", fetch_cnt[0], 1);
        pulse_start();
        @(negedge clk);
        check("t5_restart_halted", halted, 0);
        check("t5_restart_req", instr_req, 1);
        check("t5_restart_pc", pc, 8'h00);
        wait_halt("t5_halt2");
        check("t5_out_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            check("t5_out0", out_log[0], 8'd0);
            check("t5_retained", out_log[1], 8'd4);
        end

        // 6: reset during EXEC, then clean re-run
        do_reset(); load_clear();
        rom[0] = ins_r(OP_OUT, 2'd0, 2'd1);
        rom[1] = ins_i(OP_MOV, 2'd1, 8'd9);
        rom[2] = ins_r(OP_OUT, 2'd0, 2'd1);
        rom[3] = ins_r(OP_HALT, 2'd0, 2'd0);
        pulse_start();
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (alu_en) begin found = 1; break; end
        end
        check("t6_exec_seen", found, 1);
        rst = 1;
        @(negedge clk);
        check("t6_pc", pc, 8'h00);
        check("t6_req", instr_req, 0);
        check("t6_alu_en", alu_en, 0);
        check("t6_halted", halted, 0);
        check("t6_out_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1; rst = 0;
        load_clear();
        rom[0] = ins_r(OP_OUT, 2'd0, 2'd1);
        rom[1] = ins_i(OP_MOV, 2'd1, 8'd9);
        rom[2] = ins_r(OP_OUT, 2'd0, 2'd1);
        rom[3] = ins_r(OP_HALT, 2'd0, 2'd0);
        pulse_start();
        wait_halt("t6_halt");
        check("t6_out_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            check("t6_discarded", out_log[0], 8'd0);
            check("t6_rerun", out_log[1], 8'd9);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
